ikaopm_so_decoder: RTL

Receive-side companion of the OPM serial sound output: deserialises the 1-bit floating-point SO stream (two 16-slot frames per 32-slot sample period, R then L), tracks frame alignment, and expands each frame back into a signed 16-bit PCM word per channel. It sits between the OPM core's SO output and the emulated DAC/mixer path. It stands in for an external floating-point DAC and cross-checks the core's parallel PCM outputs.

---
 rtl/ikaopm_so_pkg.sv | 20 ++
 rtl/ikaopm_fp_expand.sv | 24 ++
 rtl/ikaopm_so_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/ikaopm_so_pkg.sv
// Shared constants and types for the OPM serial-output (SO) receive path.
package ikaopm_so_pkg;

  localparam int          FRAME_LEN    = 16;
  localparam logic [3:0]  SLOT_MANT_LO = 4'd1;
  localparam logic [3:0]  SLOT_SIGN    = 4'd10;
  localparam logic [3:0]  SLOT_EXP_LO  = 4'd11;
  localparam logic [3:0]  SLOT_EXP_HI  = 4'd13;
  localparam logic [3:0]  SLOT_DECODE  = 4'd14;

  typedef enum logic {UNSYNC, SYNC} lock_state_e;

  // Field order matches the shift direction: slot f1 ends in bit 0, f13 in bit 12.
  typedef struct packed {
    logic [2:0] e;
    logic       s;
    logic [8:0] m;
  } so_frame_t;

endpackage

// File: rtl/ikaopm_fp_expand.sv
// Floating-point SO frame (m, S, e) to signed 16-bit PCM; shared by both channels.
module ikaopm_fp_expand (
  input  logic [8:0]         m,
  input  logic               s,
  input  logic [2:0]         e,
  output logic signed [15:0] po,
  output logic               e_zero
);

  logic [2:0]  e_eff;
  logic [14:0] field;
  logic [14:0] body;

  always_comb begin
    e_zero = (e == 3'd0);
    e_eff  = e_zero ? 3'd1 : e;
    // Fill bits above the mantissa sit at the top; shifting drops the ones that
    // the mantissa displaces and zero-fills below it.
    field  = {{6{~s}}, m};
    body   = field << (e_eff - 3'd1);
    po     = {~s, body};
  end

endmodule

// File: rtl/ikaopm_so_decoder.sv
// Deserialises the OPM SO stream, tracks frame lock and expands each frame to PCM.
module ikaopm_so_decoder
  import ikaopm_so_pkg::*;
(
  input  logic               i_EMUCLK,
  input  logic               i_MRST,
  input  logic               i_phi1_NCEN_n,
  input  logic               i_SO,
  input  logic               i_SLOT0,
  output logic signed [15:0] o_R_PO,
  output logic signed [15:0] o_L_PO,
  output logic               o_R_VALID,
  output logic               o_L_VALID,
  output logic               o_LOCKED,
  output logic               o_SYNC_ERR
);

  lock_state_e st, st_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [3:0]  f;
  logic        miss, miss_nx;
  logic        skip, skip_nx;
  logic        dec, err_set, slip, cap;
  so_frame_t   sr;
  logic signed [15:0] po;
  logic        e_zero;

  ikaopm_fp_expand u_expand (
    .m      (sr.m),
    .s      (sr.s),
    .e      (sr.e),
    .po     (po),
    .e_zero (e_zero)
  );

  assign f = cnt[3:0];

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    miss_nx = miss;
    skip_nx = skip;
    dec     = 1'b0;
    err_set = 1'b0;
    slip    = (st == SYNC) && i_SLOT0 && (cnt != 5'd0);
    cap     = (st == SYNC) && !slip && (f >= SLOT_MANT_LO) && (f <= SLOT_EXP_HI);
    case (st)
      UNSYNC: begin
        if (i_SLOT0) begin
          st_nx   = SYNC;
          cnt_nx  = 5'd1;
          miss_nx = 1'b0;
          skip_nx = 1'b1;
        end
      end
      SYNC: begin
        cnt_nx = cnt + 5'd1;
        if (slip) begin
          cnt_nx  = 5'd1;
          err_set = 1'b1;
        end else begin
          // One missing marker is tolerated; the second in a row drops lock.
          if (cnt == 5'd0) begin
            if (i_SLOT0)   miss_nx = 1'b0;
            else if (miss) begin
              st_nx   = UNSYNC;
              cnt_nx  = 5'd0;
              miss_nx = 1'b0;
            end else       miss_nx = 1'b1;
          end
          if (i_SO && ((f == 4'd0) || (f > SLOT_DECODE))) err_set = 1'b1;
          if (f == SLOT_DECODE) begin
            if (skip) skip_nx = 1'b0;
            else begin
              dec = 1'b1;
              if (e_zero) err_set = 1'b1;
            end
          end
        end
      end
      default: st_nx = UNSYNC;
    endcase
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      st         <= UNSYNC;
      cnt        <= 5'd0;
      miss       <= 1'b0;
      skip       <= 1'b0;
      sr         <= '0;
      o_R_PO     <= '0;
      o_L_PO     <= '0;
      o_R_VALID  <= 1'b0;
      o_L_VALID  <= 1'b0;
      o_SYNC_ERR <= 1'b0;
    end else if (!i_phi1_NCEN_n) begin
      st         <= st_nx;
      cnt        <= cnt_nx;
      miss       <= miss_nx;
      skip       <= skip_nx;
      if (cap) sr <= so_frame_t'({i_SO, sr[12:1]});
      o_R_VALID  <= dec & ~cnt[4];
      o_L_VALID  <= dec &  cnt[4];
      if (dec && !cnt[4]) o_R_PO <= po;
      if (dec &&  cnt[4]) o_L_PO <= po;
      o_SYNC_ERR <= o_SYNC_ERR | err_set;
    end
  end

  assign o_LOCKED = (st == SYNC);

endmodule
